// File: rtl/spram_access_ctrl.sv
// spram_access_ctrl: merges a write stream and a read-request stream onto a single-port SRAM wrapper
// and returns read data in order through a credit-protected response FIFO.
// Optional build macro SPRAM_ARB_RR_EN selects round-robin arbitration (default: fixed write priority).
module spram_access_ctrl #(
    parameter int AW        = 8,
    parameter int DW        = 48,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,

    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,

    output logic          sram_ena,
    output logic          sram_wea,
    output logic          sram_enb,
    output logic          sram_regceb,
    output logic [AW-1:0] sram_addra,
    output logic [AW-1:0] sram_addrb,
    output logic [DW-1:0] sram_dina,
    input  logic [DW-1:0] sram_doutb
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + RD_LAT + 2);

    logic [RD_LAT-1:0] rd_tag;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     inflight;
    logic [DW-1:0]     fifo_mem [RSP_DEPTH];
    logic [PW-1:0]     fifo_wr_ptr;
    logic [PW-1:0]     fifo_rd_ptr;

    logic credit_ok;
    logic write_wins;
    logic rd_fire;
    logic wr_fire;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reads issued but not yet captured: the one on the SRAM port plus every tag still in the pipe.
    always_comb begin
        inflight = CW'(sram_enb);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(rd_tag[i]);
        end
    end

    assign credit_ok = (fifo_count + inflight) < CW'(RSP_DEPTH);

`ifdef SPRAM_ARB_RR_EN
    logic rr_ptr;

    assign write_wins = wr_valid & ~rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (wr_valid && rd_valid && credit_ok) begin
            rr_ptr <= ~rr_ptr;
        end
    end
`else
    assign write_wins = wr_valid;
`endif

    assign rd_ready = rst_n & credit_ok & ~write_wins;
    assign rd_fire  = rd_valid & rd_ready;
    assign wr_ready = rst_n & ~rd_fire;
    assign wr_fire  = wr_valid & wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_ena    <= 1'b0;
            sram_wea    <= 1'b0;
            sram_enb    <= 1'b0;
            sram_regceb <= 1'b0;
            sram_addra  <= '0;
            sram_addrb  <= '0;
            sram_dina   <= '0;
            rd_tag      <= '0;
        end else begin
            sram_ena    <= wr_fire;
            sram_wea    <= wr_fire;
            sram_enb    <= rd_fire;
            sram_regceb <= 1'b1;
            if (wr_fire) begin
                sram_addra <= wr_addr;
                sram_dina  <= wr_data;
            end
            if (rd_fire) begin
                sram_addrb <= rd_addr;
            end
            rd_tag <= (rd_tag << 1) | RD_LAT'(sram_enb);
        end
    end

    // The oldest tag marks the cycle in which sram_doutb carries that read's data.
    assign push = rd_tag[RD_LAT-1];
    assign pop  = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr] <= sram_doutb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (push) begin
                fifo_wr_ptr <= ptr_next(fifo_wr_ptr);
            end
            if (pop) begin
                fifo_rd_ptr <= ptr_next(fifo_rd_ptr);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    assign rsp_valid = (fifo_count != '0);
    assign rsp_data  = fifo_mem[fifo_rd_ptr];

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Bench for spram_access_ctrl: an RD_LAT=2 instance (directed + random traffic) and an RD_LAT=1
// instance (full-array sweep), each behind a behavioural SRAM and checked against a reference model.
module tb_spram_access_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 48;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rsp_data;
    logic          sram_ena, sram_wea, sram_enb, sram_regceb;
    logic [AW-1:0] sram_addra, sram_addrb;
    logic [DW-1:0] sram_dina, sram_doutb;

    logic          ll_wr_valid, ll_wr_ready, ll_rd_valid, ll_rd_ready, ll_rsp_valid, ll_rsp_ready;
    logic [AW-1:0] ll_wr_addr, ll_rd_addr;
    logic [DW-1:0] ll_wr_data, ll_rsp_data;
    logic          ll_sram_ena, ll_sram_wea, ll_sram_enb, ll_sram_regceb;
    logic [AW-1:0] ll_sram_addra, ll_sram_addrb;
    logic [DW-1:0] ll_sram_dina, ll_sram_doutb;

    spram_access_ctrl #(.AW(AW), .DW(DW), .RD_LAT(2), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .sram_ena(sram_ena), .sram_wea(sram_wea), .sram_enb(sram_enb), .sram_regceb(sram_regceb),
        .sram_addra(sram_addra), .sram_addrb(sram_addrb), .sram_dina(sram_dina),
        .sram_doutb(sram_doutb)
    );

    spram_access_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1), .RSP_DEPTH(DEPTH)) dut_ll (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(ll_wr_valid), .wr_ready(ll_wr_ready), .wr_addr(ll_wr_addr), .wr_data(ll_wr_data),
        .rd_valid(ll_rd_valid), .rd_ready(ll_rd_ready), .rd_addr(ll_rd_addr),
        .rsp_valid(ll_rsp_valid), .rsp_ready(ll_rsp_ready), .rsp_data(ll_rsp_data),
        .sram_ena(ll_sram_ena), .sram_wea(ll_sram_wea), .sram_enb(ll_sram_enb),
        .sram_regceb(ll_sram_regceb), .sram_addra(ll_sram_addra), .sram_addrb(ll_sram_addrb),
        .sram_dina(ll_sram_dina), .sram_doutb(ll_sram_doutb)
    );

    // Behavioural SRAM macros: HIGH_PERFORMANCE (output register) and LOW_LATENCY.
    logic [DW-1:0] hp_array [256];
    logic [DW-1:0] hp_stage1, hp_stage2;
    always @(posedge clk) begin
        if (sram_ena && sram_wea) hp_array[sram_addra] <= sram_dina;
        if (sram_enb) hp_stage1 <= hp_array[sram_addrb];
        if (sram_regceb) hp_stage2 <= hp_stage1;
    end
    assign sram_doutb = hp_stage2;

    logic [DW-1:0] ll_array [256];
    logic [DW-1:0] ll_stage1;
    always @(posedge clk) begin
        if (ll_sram_ena && ll_sram_wea) ll_array[ll_sram_addra] <= ll_sram_dina;
        if (ll_sram_enb) ll_stage1 <= ll_array[ll_sram_addrb];
    end
    assign ll_sram_doutb = ll_stage1;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] rand48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // Reference model: memory image updated on accepted writes, expected-response queue fed on
    // accepted reads, drained and compared as the consumer takes responses. Reset discards all.
    logic [DW-1:0] hp_ref [256];
    logic [DW-1:0] hp_exp [$];
    always @(negedge clk) begin
        if (!rst_n) begin
            hp_exp.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                checkOutput("hp_rsp_pending", DW'(hp_exp.size() != 0), DW'(1));
                if (hp_exp.size() != 0) checkOutput("hp_rsp_data", rsp_data, hp_exp.pop_front());
            end
            checkOutput("hp_single_access", DW'(wr_valid && wr_ready && rd_valid && rd_ready), DW'(0));
            if (wr_valid && wr_ready) hp_ref[wr_addr] = wr_data;
            if (rd_valid && rd_ready) hp_exp.push_back(hp_ref[rd_addr]);
            checkOutput("hp_no_overflow", DW'(hp_exp.size() <= DEPTH), DW'(1));
        end
    end

    logic [DW-1:0] ll_ref [256];
    logic [DW-1:0] ll_exp [$];
    always @(negedge clk) begin
        if (!rst_n) begin
            ll_exp.delete();
        end else begin
            if (ll_rsp_valid && ll_rsp_ready) begin
                checkOutput("ll_rsp_pending", DW'(ll_exp.size() != 0), DW'(1));
                if (ll_exp.size() != 0) checkOutput("ll_rsp_data", ll_rsp_data, ll_exp.pop_front());
            end
            if (ll_wr_valid && ll_wr_ready) ll_ref[ll_wr_addr] = ll_wr_data;
            if (ll_rd_valid && ll_rd_ready) ll_exp.push_back(ll_ref[ll_rd_addr]);
            checkOutput("ll_no_overflow", DW'(ll_exp.size() <= DEPTH), DW'(1));
        end
    end

    task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic rv, input logic [AW-1:0] ra, input logic rr);
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        rd_valid  = rv;
        rd_addr   = ra;
        rsp_ready = rr;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drainHp(input string tag);
        for (int n = 0; n < 30 && hp_exp.size() != 0; n++) nextCycle();
        checkOutput(tag, DW'(hp_exp.size()), DW'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [DW-1:0] d [3];
        logic [DW-1:0] pattern;
        int wr_n, rd_n, waited;

        rst_n = 1'b0;
        applyStimulus(0, '0, '0, 0, '0, 0);
        ll_wr_valid = 0; ll_wr_addr = '0; ll_wr_data = '0;
        ll_rd_valid = 0; ll_rd_addr = '0; ll_rsp_ready = 0;

        // Reset state and release
        nextCycle();
        @(negedge clk);
        checkOutput("rst_wr_ready", DW'(wr_ready), DW'(0));
        checkOutput("rst_rd_ready", DW'(rd_ready), DW'(0));
        checkOutput("rst_regceb", DW'(sram_regceb), DW'(0));
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t1_enables", DW'({sram_ena, sram_wea, sram_enb}), DW'(0));
        checkOutput("t1_rsp_valid", DW'(rsp_valid), DW'(0));
        checkOutput("t1_rd_ready", DW'(rd_ready), DW'(1));
        checkOutput("t1_wr_ready", DW'(wr_ready), DW'(1));
        nextCycle();
        @(negedge clk);
        checkOutput("t1_regceb", DW'(sram_regceb), DW'(1));
        checkOutput("t1_ll_regceb", DW'(ll_sram_regceb), DW'(1));
        nextCycle();

        // Write then read-after-write, RD_LAT=2 timing
        pattern = 48'h00A5A5A5A5A5;
        applyStimulus(1, 8'h10, pattern, 0, '0, 0);
        @(negedge clk);
        checkOutput("t2_wr_ready", DW'(wr_ready), DW'(1));
        nextCycle();
        applyStimulus(0, '0, '0, 1, 8'h10, 0);
        @(negedge clk);
        checkOutput("t2_ena_wea", DW'({sram_ena, sram_wea}), DW'(2'b11));
        checkOutput("t2_addra", DW'(sram_addra), DW'(8'h10));
        checkOutput("t2_dina", sram_dina, pattern);
        checkOutput("t2_rd_ready", DW'(rd_ready), DW'(1));
        nextCycle();
        applyStimulus(0, '0, '0, 0, '0, 0);
        @(negedge clk);
        checkOutput("t2_enb", DW'({sram_ena, sram_enb}), DW'(2'b01));
        checkOutput("t2_addrb", DW'(sram_addrb), DW'(8'h10));
        checkOutput("t2_rsp_valid_c0", DW'(rsp_valid), DW'(0));
        nextCycle();
        @(negedge clk);
        checkOutput("t2_enb_pulse", DW'(sram_enb), DW'(0));
        checkOutput("t2_rsp_valid_c1", DW'(rsp_valid), DW'(0));
        nextCycle();
        @(negedge clk);
        checkOutput("t2_rsp_valid_c2", DW'(rsp_valid), DW'(0));
        nextCycle();
        rsp_ready = 1;
        @(negedge clk);
        checkOutput("t2_rsp_valid_c3", DW'(rsp_valid), DW'(1));
        checkOutput("t2_rsp_data", rsp_data, pattern);
        nextCycle();
        @(negedge clk);
        checkOutput("t2_rsp_popped", DW'(rsp_valid), DW'(0));
        nextCycle();

        // Credit limit under backpressure
        for (int i = 0; i < 3; i++) begin
            d[i] = rand48();
            applyStimulus(1, AW'(8'h20 + i), d[i], 0, '0, 0);
            nextCycle();
        end
        applyStimulus(0, '0, '0, 1, 8'h20, 0);
        @(negedge clk);
        checkOutput("t3_rd_ready_0", DW'(rd_ready), DW'(1));
        nextCycle();
        applyStimulus(0, '0, '0, 1, 8'h21, 0);
        @(negedge clk);
        checkOutput("t3_rd_ready_1", DW'(rd_ready), DW'(1));
        nextCycle();
        applyStimulus(0, '0, '0, 1, 8'h22, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("t3_rd_blocked", DW'(rd_ready), DW'(0));
            nextCycle();
        end
        rsp_ready = 1;
        @(negedge clk);
        checkOutput("t3_first_valid", DW'(rsp_valid), DW'(1));
        checkOutput("t3_first_data", rsp_data, d[0]);
        checkOutput("t3_still_full", DW'(rd_ready), DW'(0));
        nextCycle();
        @(negedge clk);
        checkOutput("t3_second_data", rsp_data, d[1]);
        checkOutput("t3_third_accept", DW'(rd_ready), DW'(1));
        nextCycle();
        applyStimulus(0, '0, '0, 0, '0, 1);
        drainHp("t3_drain");

        // Both requesters held high
        wr_n = 0;
        rd_n = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, AW'(8'h40 + i), rand48(), 1, 8'h10, 1);
            @(negedge clk);
            if (wr_valid && wr_ready) wr_n++;
            if (rd_valid && rd_ready) rd_n++;
            nextCycle();
        end
        applyStimulus(0, '0, '0, 0, '0, 1);
`ifdef SPRAM_ARB_RR_EN
        checkOutput("t4_total_grants", DW'(wr_n + rd_n), DW'(6));
        checkOutput("t4_reads_served", DW'(rd_n >= 2), DW'(1));
`else
        checkOutput("t4_writes", DW'(wr_n), DW'(6));
        checkOutput("t4_reads", DW'(rd_n), DW'(0));
`endif
        drainHp("t4_drain");

        // Reset with two reads in flight
        applyStimulus(0, '0, '0, 1, 8'h20, 0);
        nextCycle();
        applyStimulus(0, '0, '0, 1, 8'h21, 0);
        nextCycle();
        applyStimulus(0, '0, '0, 0, '0, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rsp_valid_rst", DW'(rsp_valid), DW'(0));
        checkOutput("t5_enb_rst", DW'(sram_enb), DW'(0));
        checkOutput("t5_ready_rst", DW'({wr_ready, rd_ready}), DW'(0));
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        rsp_ready = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("t5_no_stale_rsp", DW'(rsp_valid), DW'(0));
            nextCycle();
        end
        @(negedge clk);
        checkOutput("t5_credits_restored", DW'(rd_ready), DW'(1));
        nextCycle();

        // Randomised mixed traffic on a small address window
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, AW'(8'h30 + i), rand48(), 0, '0, 1);
            nextCycle();
        end
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), AW'(8'h30 + $urandom_range(0, 7)), rand48(),
                          1'($urandom_range(0, 1)), AW'(8'h30 + $urandom_range(0, 7)),
                          ($urandom_range(0, 3) != 0));
            nextCycle();
        end
        applyStimulus(0, '0, '0, 0, '0, 1);
        drainHp("rand_drain");

        // LOW_LATENCY sweep over the full array
        ll_rsp_ready = 1;
        for (int i = 0; i < 256; i++) begin
            ll_wr_valid = 1;
            ll_wr_addr  = AW'(i);
            ll_wr_data  = rand48();
            waited = 0;
            @(negedge clk);
            while (!ll_wr_ready && waited < 20) begin
                nextCycle();
                @(negedge clk);
                waited++;
            end
            checkOutput("ll_wr_accept", DW'(ll_wr_ready), DW'(1));
            nextCycle();
        end
        ll_wr_valid = 0;
        for (int i = 0; i < 256; i++) begin
            ll_rd_valid = 1;
            ll_rd_addr  = AW'(i);
            waited = 0;
            @(negedge clk);
            while (!ll_rd_ready && waited < 20) begin
                nextCycle();
                @(negedge clk);
                waited++;
            end
            checkOutput("ll_rd_accept", DW'(ll_rd_ready), DW'(1));
            nextCycle();
        end
        ll_rd_valid = 0;
        for (int n = 0; n < 30 && ll_exp.size() != 0; n++) nextCycle();
        checkOutput("ll_drain", DW'(ll_exp.size()), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
